// File: rtl/note_sequencer_if.sv
// note_sequencer_if: song ROM, note-player and user-control signals of the note sequencer.
interface note_sequencer_if #(
   parameter int SONG_BITS = 2,
   parameter int IDX_BITS  = 5
);
   logic                          play;
   logic                          next_song;
   logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
   logic [11:0]                   rom_dout;
   logic [5:0]                    note_to_load;
   logic [5:0]                    duration_to_load;
   logic                          load_new_note;
   logic                          done_with_note;
   logic                          play_enable;
   logic [SONG_BITS-1:0]          song_index;
   logic                          song_done;
   modport master (
      input  play, next_song, rom_dout, done_with_note,
      output rom_addr, note_to_load, duration_to_load, load_new_note,
             play_enable, song_index, song_done
   );
   modport slave (
      output play, next_song, rom_dout, done_with_note,
      input  rom_addr, note_to_load, duration_to_load, load_new_note,
             play_enable, song_index, song_done
   );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: walks the song ROM and feeds notes to the note player.
// Define SEQ_LOOP_EN to restart the current song at its end instead of stopping.
module note_sequencer #(
   parameter int SONG_BITS = 2,
   parameter int IDX_BITS  = 5
) (
   input logic               clk,
   input logic               reset,
   note_sequencer_if.master  bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_LOAD, S_WAIT, S_END} state_t;
   state_t                        state_q, state_d;
   logic [SONG_BITS-1:0]          song_q, song_d;
   logic [IDX_BITS-1:0]           idx_q, idx_d;
   logic [SONG_BITS+IDX_BITS-1:0] addr_q;
   logic [5:0]                    note_q, note_d, dur_q, dur_d;
   logic                          done_q, end_hit;
   assign bus.rom_addr         = addr_q;
   assign bus.note_to_load     = note_q;
   assign bus.duration_to_load = dur_q;
   assign bus.song_index       = song_q;
   assign bus.song_done        = done_q;
   assign bus.load_new_note    = (state_q == S_LOAD) && bus.play;
   assign bus.play_enable      = bus.play && (state_q != S_IDLE) && (state_q != S_END);
   always_comb begin
      state_d = state_q;
      song_d  = song_q;
      idx_d   = idx_q;
      note_d  = note_q;
      dur_d   = dur_q;
      end_hit = 1'b0;
      // next_song outranks everything, including a done_with_note in the same cycle
      if (bus.next_song && state_q != S_IDLE) begin
         song_d  = song_q + 1'b1;
         idx_d   = '0;
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_IDLE:  if (bus.next_song) song_d = song_q + 1'b1;
                     else if (bus.play) state_d = S_FETCH;
            S_FETCH: if (bus.play) state_d = S_READ;
            S_READ:  if (bus.play) begin
                        if (bus.rom_dout[5:0] == 6'd0) end_hit = 1'b1;
                        else begin
                           note_d  = bus.rom_dout[11:6];
                           dur_d   = bus.rom_dout[5:0];
                           state_d = S_LOAD;
                        end
                     end
            S_LOAD:  if (bus.play) state_d = S_WAIT;
            S_WAIT:  if (bus.play && bus.done_with_note) begin
                        if (&idx_q) end_hit = 1'b1;
                        else begin
                           idx_d   = idx_q + 1'b1;
                           state_d = S_FETCH;
                        end
                     end
            S_END:   if (!bus.play) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                     end
            default: state_d = S_IDLE;
         endcase
         if (end_hit) begin
`ifdef SEQ_LOOP_EN
            idx_d   = '0;
            state_d = S_FETCH;
`else
            state_d = S_END;
`endif
         end
      end
   end
   // rom_addr tracks the next position so it is already valid on FETCH entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         song_q  <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         note_q  <= '0;
         dur_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         song_q  <= song_d;
         idx_q   <= idx_d;
         addr_q  <= {song_d, idx_d};
         note_q  <= note_d;
         dur_q   <= dur_d;
         done_q  <= end_hit;
      end
   end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer against a small behavioural song ROM.
module tb_note_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] rom [128];
   int          n_chk = 0;
   int          n_pass = 0;
   note_sequencer_if bus ();
   note_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      else n_pass++;
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic pulse_done();
      bus.done_with_note = 1'b1;
      tick();
      bus.done_with_note = 1'b0;
   endtask
   task automatic pulse_next();
      bus.next_song = 1'b1;
      tick();
      bus.next_song = 1'b0;
   endtask
   // called in FETCH; leaves the bench at the first WAIT cycle
   task automatic load_seq(input int n, input int d, input string tag);
      tick();
      check({tag, "_read_noload"}, bus.load_new_note, 0);
      tick();
      check({tag, "_load"}, bus.load_new_note, 1);
      check({tag, "_note"}, bus.note_to_load, n);
      check({tag, "_dur"}, bus.duration_to_load, d);
      tick();
      check({tag, "_wait_noload"}, bus.load_new_note, 0);
   endtask
   initial begin
      int loads, pe;
      for (int i = 0; i < 128; i++) rom[i] = '0;
      rom[0] = {6'd20, 6'd4};
      rom[1] = {6'd25, 6'd2};
      for (int k = 0; k < 5; k++) rom[32+k] = {6'(k+1), 6'd3};
      for (int k = 0; k < 32; k++) rom[64+k] = {6'(k+10), 6'd1};
      rom[96] = {6'd40, 6'd5};
      rom[97] = {6'd41, 6'd5};
      reset = 1'b0;
      bus.play = 1'b0;
      bus.next_song = 1'b0;
      bus.done_with_note = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("rst_addr", bus.rom_addr, 0);
      check("rst_note", bus.note_to_load, 0);
      check("rst_dur", bus.duration_to_load, 0);
      check("rst_load", bus.load_new_note, 0);
      check("rst_song_done", bus.song_done, 0);
      check("rst_play_en", bus.play_enable, 0);
      check("rst_song", bus.song_index, 0);
      // basic song 0 playback
      bus.play = 1'b1;
      tick();
      check("s0_fetch_addr", bus.rom_addr, 0);
      check("s0_play_en", bus.play_enable, 1);
      load_seq(20, 4, "s0n0");
      repeat (2) tick();
      pulse_done();
      check("s0_addr1", bus.rom_addr, 1);
      load_seq(25, 2, "s0n1");
      pulse_done();
      tick();
      check("s0_done_early", bus.song_done, 0);
      tick();
      check("s0_song_done", bus.song_done, 1);
`ifdef SEQ_LOOP_EN
      check("s0_end_play_en", bus.play_enable, 1);
      check("s0_loop_addr", bus.rom_addr, 0);
`else
      check("s0_end_play_en", bus.play_enable, 0);
`endif
      tick();
      check("s0_done_once", bus.song_done, 0);
      // pause in WAIT
      bus.play = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      bus.play = 1'b1;
      tick();
      load_seq(20, 4, "p_n0");
      bus.play = 1'b0;
      #1 check("pause_play_en", bus.play_enable, 0);
      loads = 0;
      pe = 0;
      repeat (50) begin
         tick();
         if (bus.load_new_note) loads++;
         if (bus.play_enable) pe++;
      end
      check("pause_loads", loads, 0);
      check("pause_pe_cycles", pe, 0);
      check("pause_addr", bus.rom_addr, 0);
      bus.play = 1'b1;
      #1 check("resume_play_en", bus.play_enable, 1);
      pulse_done();
      check("resume_addr", bus.rom_addr, 1);
      load_seq(25, 2, "p_n1");
      // next_song in IDLE, then during WAIT of song 3
      bus.play = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      repeat (3) pulse_next();
      check("idle_song3", bus.song_index, 3);
      check("idle_addr96", bus.rom_addr, 96);
      check("idle_play_en", bus.play_enable, 0);
      bus.play = 1'b1;
      tick();
      load_seq(40, 5, "s3n0");
      pulse_next();
      check("wrap_song0", bus.song_index, 0);
      check("wrap_addr0", bus.rom_addr, 0);
      load_seq(20, 4, "wrap_n0");
      // next_song with done_with_note at note_idx 3 of song 1
      pulse_next();
      check("s1_addr", bus.rom_addr, 32);
      for (int k = 0; k < 3; k++) begin
         load_seq(k + 1, 3, $sformatf("s1n%0d", k));
         pulse_done();
      end
      check("s1_addr3", bus.rom_addr, 35);
      load_seq(4, 3, "s1n3");
      bus.next_song = 1'b1;
      bus.done_with_note = 1'b1;
      tick();
      bus.next_song = 1'b0;
      bus.done_with_note = 1'b0;
      check("both_addr", bus.rom_addr, 64);
      check("both_song", bus.song_index, 2);
      // 32-entry song without end marker
      for (int k = 0; k < 32; k++) begin
         load_seq(k + 10, 1, $sformatf("s2n%0d", k));
         pulse_done();
      end
      check("s2_song_done", bus.song_done, 1);
`ifdef SEQ_LOOP_EN
      check("s2_loop_addr", bus.rom_addr, 64);
      load_seq(10, 1, "s2_reload");
`else
      check("s2_end_play_en", bus.play_enable, 0);
      loads = 0;
      repeat (6) begin
         tick();
         if (bus.load_new_note) loads++;
      end
      check("s2_no_33rd_load", loads, 0);
`endif
      // asynchronous reset while in LOAD
      pulse_next();
      tick();
      tick();
      check("rl_load_before", bus.load_new_note, 1);
      reset = 1'b0;
      #1;
      check("rl_load", bus.load_new_note, 0);
      check("rl_note", bus.note_to_load, 0);
      check("rl_dur", bus.duration_to_load, 0);
      check("rl_addr", bus.rom_addr, 0);
      check("rl_song", bus.song_index, 0);
      check("rl_play_en", bus.play_enable, 0);
      check("rl_song_done", bus.song_done, 0);
      tick();
      reset = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
